// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop, LSB first.
// Result and carry-out are published only on the completion edge.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] r_sh;
    logic             c;
    logic [CNT_W-1:0] cnt;

    logic             s_c;
    logic             c_next_c;
    logic [WIDTH-1:0] r_next_c;

    // Full-adder cell on the current LSBs; r_next_c is the result with this bit at the MSB.
    assign s_c      = a_sh[0] ^ b_sh[0] ^ c;
    assign c_next_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    assign r_next_c = {s_c, r_sh};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // DONE accepts a new start exactly like IDLE for back-to-back operation.
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c     <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    r_sh <= r_next_c[WIDTH-1:1];
                    c    <= c_next_c;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        sum   <= r_next_c;
                        cout  <= c_next_c;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: the driver queues expected {cout,sum},
// an independent monitor pops and compares on every done pulse.
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH:0] exp_q[$];
    logic           rst_seen = 1'b0;
    logic           stop_mon = 1'b0;
    int             done_total = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Remember whether the last edge was a reset edge.
    always @(posedge clk) rst_seen = !rst_n;

    // Monitor: compares results on done, checks output stability otherwise.
    initial begin : monitor
        logic [WIDTH:0] last;
        logic [WIDTH:0] exp;
        last = '0;
        while (!stop_mon) begin
            @(negedge clk);
            if (busy && done) check("busy_and_done", 32'(1), 32'(0));
            if (rst_seen) begin
                last = '0;
                check("reset_outputs", 32'({cout, sum}), 32'(0));
                check("reset_done", 32'(done), 32'(0));
            end else if (done) begin
                done_total++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'({cout, sum}), 32'h1_dead);
                end else begin
                    exp = exp_q.pop_front();
                    check("result", 32'({cout, sum}), 32'(exp));
                end
                last = {cout, sum};
            end else if ({cout, sum} !== last) begin
                check("stable_between_done", 32'({cout, sum}), 32'(last));
            end
        end
    end

    // Issue one operation and return how many negedges after acceptance done appears.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tc, input logic [WIDTH:0] expv, output int idx);
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb; cin = ~tc;
        idx = 1;
        while (!done && idx < 20) begin
            @(negedge clk);
            idx++;
        end
        if (!done) check("timeout_waiting_done", 32'(0), 32'(1));
    endtask

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c;
        logic [WIDTH:0]   e;
    } vec_t;

    initial begin : driver
        int idx;
        int busy_cnt;
        int done_cnt;
        int done_at;
        vec_t dir[4];
        vec_t b2b[4];

        dir[0] = '{8'h5A, 8'h3C, 1'b0, 9'h096};
        dir[1] = '{8'hFF, 8'h01, 1'b0, 9'h100};
        dir[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
        dir[3] = '{8'h00, 8'h00, 1'b1, 9'h001};
        b2b[0] = '{8'h01, 8'h02, 1'b0, 9'h003};
        b2b[1] = '{8'h80, 8'h80, 1'b0, 9'h100};
        b2b[2] = '{8'h7F, 8'h00, 1'b1, 9'h080};
        b2b[3] = '{8'hAA, 8'h55, 1'b1, 9'h100};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_sum", 32'({cout, sum}), 32'(0));
        rst_n = 1'b1;

        // Latency and busy window on the first vector.
        @(negedge clk);
        a = dir[0].a; b = dir[0].b; cin = dir[0].c; start = 1'b1;
        exp_q.push_back(dir[0].e);
        busy_cnt = 0; done_cnt = 0; done_at = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = k;
            end
        end
        check("busy_cycles", 32'(busy_cnt), 32'(8));
        check("done_count", 32'(done_cnt), 32'(1));
        check("done_latency", 32'(done_at), 32'(9));

        for (int i = 1; i < 4; i++) begin
            run_op(dir[i].a, dir[i].b, dir[i].c, dir[i].e, idx);
            check("directed_latency", 32'(idx), 32'(9));
        end

        // Start pulsed during RUN must be ignored.
        repeat (2) @(negedge clk);
        done_cnt = done_total;
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        exp_q.push_back(9'h030);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("ignored_start_done_count", 32'(done_total - done_cnt), 32'(1));

        // Reset in the middle of RUN discards the operation.
        done_cnt = done_total;
        a = 8'h33; b = 8'h44; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun_reset_busy", 32'(busy), 32'(0));
        check("midrun_reset_sum", 32'({cout, sum}), 32'(0));
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("midrun_reset_no_done", 32'(done_total - done_cnt), 32'(0));
        run_op(8'h33, 8'h44, 1'b1, 9'h078, idx);
        check("after_reset_latency", 32'(idx), 32'(9));

        // Back-to-back: start held high, new operands presented in each DONE cycle.
        @(negedge clk);
        a = b2b[0].a; b = b2b[0].b; cin = b2b[0].c; start = 1'b1;
        exp_q.push_back(b2b[0].e);
        for (int i = 0; i < 4; i++) begin
            idx = 0;
            do begin
                @(negedge clk);
                idx++;
            end while (!done && idx < 20);
            check("b2b_spacing", 32'(idx), 32'(9));
            if (i < 3) begin
                a = b2b[i+1].a; b = b2b[i+1].b; cin = b2b[i+1].c;
                exp_q.push_back(b2b[i+1].e);
            end else begin
                start = 1'b0;
            end
        end

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 1000; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             rc;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            run_op(ra, rb, rc, (WIDTH+1)'(ra) + (WIDTH+1)'(rb) + (WIDTH+1)'(rc), idx);
            if (idx != 9) check("random_latency", 32'(idx), 32'(9));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        stop_mon = 1'b1;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
